// File: rtl/wave_rd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wave_rd_ctrl: reads one buffered sample per window column, draws it with
// vertical interpolation, and handshakes a fully drawn frame to the sampler.
// Revision: 1.0
// ---------------------------------------------------------------------------
module wave_rd_ctrl #(
  parameter int WAVE_WIDTH = 1024,
  parameter int H_START    = 128,
  parameter int V_START    = 112
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        vs,
  input  logic [11:0] h_cnt,
  input  logic [11:0] v_cnt,
  input  logic        wave_run,
  input  logic        data_ready,
  input  logic [7:0]  ram_rd_data,
  output logic [11:0] wave_rd_addr,
  output logic        wr_over,
  output logic        wave_de,
  output logic        wave_pixel
);

  localparam logic [11:0] H_LO = 12'(H_START);
  localparam logic [11:0] H_HI = 12'(H_START + WAVE_WIDTH - 1);
  localparam logic [11:0] V_LO = 12'(V_START);
  localparam logic [11:0] V_HI = 12'(V_START + 255);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        wr_over_q, wr_over_d;
  logic        vs_q, vs_d;
  logic [11:0] addr_q, addr_d;
  logic        hit1_q, hit1_d, de1_q, de1_d, first1_q, first1_d;
  logic [7:0]  row1_q, row1_d;
  logic        hit2_q, hit2_d, de2_q, de2_d, first2_q, first2_d;
  logic [7:0]  row2_q, row2_d;
  logic [7:0]  y_prev_q, y_prev_d;
  logic        de3_q, de3_d, pix_q, pix_d;

  logic        h_in, v_in, hit0, frame_end, vs_rise;
  logic [7:0]  y, y_lo, y_hi;

  always_comb begin
    h_in      = (h_cnt >= H_LO) && (h_cnt <= H_HI);
    v_in      = (v_cnt >= V_LO) && (v_cnt <= V_HI);
    hit0      = de && h_in && v_in;
    frame_end = de && (h_cnt == H_HI) && (v_cnt == V_HI);
    vs_rise   = vs && !vs_q;

    // Stage 1: address out, window position travels alongside the RAM read
    addr_d   = h_in ? (h_cnt - H_LO) : 12'd0;
    hit1_d   = hit0;
    de1_d    = de;
    first1_d = (h_cnt == H_LO);
    row1_d   = 8'(v_cnt - V_LO);

    hit2_d   = hit1_q;
    de2_d    = de1_q;
    first2_d = first1_q;
    row2_d   = row1_q;

    // Stage 3: sample is on ram_rd_data now; span from previous column's y
    y        = 8'd255 - ram_rd_data;
    y_lo     = (y_prev_q < y) ? y_prev_q : y;
    y_hi     = (y_prev_q < y) ? y : y_prev_q;
    y_prev_d = hit2_q ? y : y_prev_q;
    de3_d    = de2_q;
    pix_d    = hit2_q && (first2_q ? (row2_q == y)
                                   : ((row2_q >= y_lo) && (row2_q <= y_hi)));
    vs_d     = vs;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (data_ready && wave_run) state_d = ARMED;
      ARMED: begin
        if (!wave_run || !data_ready) state_d = IDLE;
        else if (vs_rise)             state_d = DRAW;
      end
      // A vs edge simply keeps us in DRAW; frame end outranks it.
      DRAW: begin
        if (!wave_run)     state_d = IDLE;
        else if (frame_end) state_d = DONE;
      end
      DONE:  if (!data_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_over_d = (state_d == DONE);
  end

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_over_q <= 1'b0;
      vs_q      <= 1'b0;
      addr_q    <= 12'd0;
      hit1_q    <= 1'b0;
      de1_q     <= 1'b0;
      first1_q  <= 1'b0;
      row1_q    <= 8'd0;
      hit2_q    <= 1'b0;
      de2_q     <= 1'b0;
      first2_q  <= 1'b0;
      row2_q    <= 8'd0;
      y_prev_q  <= 8'd0;
      de3_q     <= 1'b0;
      pix_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_over_q <= wr_over_d;
      vs_q      <= vs_d;
      addr_q    <= addr_d;
      hit1_q    <= hit1_d;
      de1_q     <= de1_d;
      first1_q  <= first1_d;
      row1_q    <= row1_d;
      hit2_q    <= hit2_d;
      de2_q     <= de2_d;
      first2_q  <= first2_d;
      row2_q    <= row2_d;
      y_prev_q  <= y_prev_d;
      de3_q     <= de3_d;
      pix_q     <= pix_d;
    end
  end

  assign wave_rd_addr = addr_q;
  assign wr_over      = wr_over_q;
  assign wave_de      = de3_q;
  assign wave_pixel   = pix_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_rd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wave_rd_ctrl: directed vectors for the pixel pipeline plus handshake
// sequences. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_wave_rd_ctrl;

  logic        pix_clk = 1'b0;
  logic        rst_n;
  logic        de, vs, wave_run, data_ready;
  logic [11:0] h_cnt, v_cnt;
  logic [7:0]  ram_rd_data;
  logic [11:0] wave_rd_addr;
  logic        wr_over, wave_de, wave_pixel;

  logic [7:0]  mem [0:1023];
  int          n_pass = 0;
  int          n_checks = 0;

  wave_rd_ctrl #(.WAVE_WIDTH(1024), .H_START(128), .V_START(112)) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .de(de), .vs(vs),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .wave_run(wave_run), .data_ready(data_ready),
    .ram_rd_data(ram_rd_data), .wave_rd_addr(wave_rd_addr),
    .wr_over(wr_over), .wave_de(wave_de), .wave_pixel(wave_pixel)
  );

  always #5 pix_clk = ~pix_clk;

  // Synchronous buffer RAM: data one cycle after the address
  always @(posedge pix_clk) ram_rd_data <= mem[wave_rd_addr[9:0]];

  typedef struct {
    logic        de;
    logic [11:0] h;
    logic [11:0] v;
    logic [11:0] exp_addr;
    logic        exp_pix;
  } vec_t;

  vec_t vecs [20];

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic drive(input logic d, input logic [11:0] h, input logic [11:0] v);
    de = d; h_cnt = h; v_cnt = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'd0;
    mem[0] = 8'd200; mem[1] = 8'd10; mem[2] = 8'd10; mem[5] = 8'd200;
    mem[10] = 8'd100; mem[11] = 8'd150;

    vecs[0]  = '{1'b1, 12'd128,  12'd167, 12'd0,    1'b1};
    vecs[1]  = '{1'b1, 12'd129,  12'd167, 12'd1,    1'b1};
    vecs[2]  = '{1'b1, 12'd130,  12'd167, 12'd2,    1'b0};
    vecs[3]  = '{1'b1, 12'd133,  12'd167, 12'd5,    1'b1};
    vecs[4]  = '{1'b1, 12'd127,  12'd167, 12'd0,    1'b0};
    vecs[5]  = '{1'b1, 12'd138,  12'd216, 12'd10,   1'b1};
    vecs[6]  = '{1'b1, 12'd139,  12'd216, 12'd11,   1'b0};
    vecs[7]  = '{1'b1, 12'd138,  12'd217, 12'd10,   1'b1};
    vecs[8]  = '{1'b1, 12'd139,  12'd217, 12'd11,   1'b1};
    vecs[9]  = '{1'b1, 12'd138,  12'd267, 12'd10,   1'b1};
    vecs[10] = '{1'b1, 12'd139,  12'd267, 12'd11,   1'b1};
    vecs[11] = '{1'b1, 12'd138,  12'd268, 12'd10,   1'b0};
    vecs[12] = '{1'b1, 12'd139,  12'd268, 12'd11,   1'b0};
    vecs[13] = '{1'b0, 12'd138,  12'd217, 12'd10,   1'b0};
    vecs[14] = '{1'b1, 12'd139,  12'd111, 12'd11,   1'b0};
    vecs[15] = '{1'b1, 12'd1151, 12'd367, 12'd1023, 1'b1};
    vecs[16] = '{1'b1, 12'd1152, 12'd367, 12'd0,    1'b0};
    vecs[17] = '{1'b1, 12'd128,  12'd368, 12'd0,    1'b0};
    vecs[18] = '{1'b1, 12'd128,  12'd212, 12'd0,    1'b0};
    vecs[19] = '{1'b1, 12'd128,  12'd167, 12'd0,    1'b1};

    rst_n = 1'b0; vs = 1'b0; wave_run = 1'b0; data_ready = 1'b0;
    drive(1'b0, 12'd0, 12'd0);
    #23;
    check("reset_addr", 32'(wave_rd_addr), 32'd0);
    check("reset_wr_over", 32'(wr_over), 32'd0);
    check("reset_wave_de", 32'(wave_de), 32'd0);
    check("reset_pixel", 32'(wave_pixel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Pixel pipeline: address after 1 edge, pixel and de after 3
    for (int k = 0; k < 22; k++) begin
      if (k < 20) drive(vecs[k].de, vecs[k].h, vecs[k].v);
      else        drive(1'b0, 12'd0, 12'd0);
      tick();
      if (k < 20) check($sformatf("addr[%0d]", k), 32'(wave_rd_addr), 32'(vecs[k].exp_addr));
      if (k >= 2) begin
        check($sformatf("pixel[%0d]", k - 2), 32'(wave_pixel), 32'(vecs[k-2].exp_pix));
        check($sformatf("wave_de[%0d]", k - 2), 32'(wave_de), 32'(vecs[k-2].de));
      end
    end

    // Armed mid-frame: that frame end must not count
    data_ready = 1'b1; wave_run = 1'b1;
    drive(1'b1, 12'd500, 12'd200); tick();
    check("armed_midframe", 32'(wr_over), 32'd0);
    drive(1'b1, 12'd1151, 12'd367); tick();
    drive(1'b0, 12'd0, 12'd0); tick();
    check("partial_frame_end", 32'(wr_over), 32'd0);
    vs = 1'b1; tick(); vs = 1'b0; tick();
    check("draw_started", 32'(wr_over), 32'd0);
    drive(1'b1, 12'd700, 12'd300); tick();
    check("draw_midframe", 32'(wr_over), 32'd0);
    vs = 1'b1; tick(); vs = 1'b0; tick();
    check("draw_restart", 32'(wr_over), 32'd0);
    drive(1'b1, 12'd1151, 12'd367); tick();
    check("frame_done", 32'(wr_over), 32'd1);
    drive(1'b0, 12'd0, 12'd0); wave_run = 1'b0; tick(); tick();
    check("done_ignores_run", 32'(wr_over), 32'd1);
    data_ready = 1'b0; tick();
    check("ready_drop", 32'(wr_over), 32'd0);

    // wave_run dropped during DRAW
    data_ready = 1'b1; wave_run = 1'b1; tick();
    vs = 1'b1; tick(); vs = 1'b0; wave_run = 1'b0; tick();
    drive(1'b1, 12'd1151, 12'd367); tick();
    drive(1'b0, 12'd0, 12'd0); tick(); tick();
    check("abort_no_wr_over", 32'(wr_over), 32'd0);
    check("draw_after_abort", 32'(wave_pixel), 32'd1);
    data_ready = 1'b0; tick();

    // vs edge and frame-end pixel together
    data_ready = 1'b1; wave_run = 1'b1; tick();
    vs = 1'b1; tick(); vs = 1'b0; tick();
    vs = 1'b1; drive(1'b1, 12'd1151, 12'd367); tick();
    vs = 1'b0;
    check("vs_and_end", 32'(wr_over), 32'd1);

    // Async reset while in DONE with live pipeline
    drive(1'b1, 12'd133, 12'd167); tick(); tick(); tick();
    check("done_before_reset", 32'(wr_over), 32'd1);
    check("de_before_reset", 32'(wave_de), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_wr_over", 32'(wr_over), 32'd0);
    check("async_addr", 32'(wave_rd_addr), 32'd0);
    check("async_wave_de", 32'(wave_de), 32'd0);
    check("async_pixel", 32'(wave_pixel), 32'd0);
    #2 rst_n = 1'b1;
    drive(1'b0, 12'd0, 12'd0); tick();
    drive(1'b1, 12'd1151, 12'd367); tick();
    drive(1'b0, 12'd0, 12'd0); tick(); tick();
    check("reset_abandons", 32'(wr_over), 32'd0);
    vs = 1'b1; tick(); vs = 1'b0; tick();
    drive(1'b1, 12'd1151, 12'd367); tick();
    drive(1'b0, 12'd0, 12'd0);
    check("post_reset_frame", 32'(wr_over), 32'd1);
    data_ready = 1'b0; tick();
    check("post_reset_release", 32'(wr_over), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
